// File: rtl/alu_seq_if.sv
// Valid/ready request and response bundle for the sequential execute-stage ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_cnt;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             err;

  // Requester side: issues operations and consumes results.
  modport master (
    output in_valid, alu_cnt, input1, input2, shamt, out_ready,
    input  in_ready, out_valid, result, hi, zero, err
  );

  // ALU side.
  modport slave (
    input  in_valid, alu_cnt, input1, input2, shamt, out_ready,
    output in_ready, out_valid, result, hi, zero, err
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops finish in one edge, MULU/DIVU iterate one
// bit per cycle; results are held until the consumer takes them.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int unsigned CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             err_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;

  logic [WIDTH-1:0] alu_res_d;
  logic             illegal_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_d;
  logic [WIDTH-1:0] mul_b_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc_d;
  logic [WIDTH-1:0] div_a_d;

  // Single-cycle results, evaluated from the operands presented at accept.
  always_comb begin
    alu_res_d = '0;
    illegal_d = 1'b0;
    case (bus.alu_cnt)
      OP_ADD:  alu_res_d = bus.input1 + bus.input2;
      OP_SUB:  alu_res_d = bus.input1 - bus.input2;
      OP_NOT:  alu_res_d = ~bus.input1;
      OP_LSL:  alu_res_d = bus.input1 << bus.shamt;
      OP_LSR:  alu_res_d = bus.input1 >> bus.shamt;
      OP_AND:  alu_res_d = bus.input1 & bus.input2;
      OP_OR:   alu_res_d = bus.input1 | bus.input2;
      OP_SLT:  alu_res_d = WIDTH'($signed(bus.input1) < $signed(bus.input2));
      OP_ASR:  alu_res_d = WIDTH'($signed(bus.input1) >>> bus.shamt);
      OP_MULU, OP_DIVU: alu_res_d = '0;
      default: illegal_d = 1'b1;
    endcase
  end

  // One shift-add multiply step ({acc,b} holds the product) and one
  // restoring divide step (a shifts out dividend bits, shifts in quotient).
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
    mul_acc_d = mul_sum[WIDTH:1];
    mul_b_d   = {mul_sum[0], b_q[WIDTH-1:1]};
    div_shift = {acc_q, a_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    // Remainder < divisor keeps the difference below 2^WIDTH when no borrow.
    div_ge    = ~div_diff[WIDTH];
    div_acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_a_d   = {a_q[WIDTH-2:0], div_ge};
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.input1;
            b_q        <= bus.input2;
            acc_q      <= '0;
            cnt_q      <= CW'(WIDTH);
            in_ready_q <= 1'b0;
            if (bus.alu_cnt == OP_MULU) begin
              state_q <= S_MUL;
            end else if (bus.alu_cnt == OP_DIVU && bus.input2 != '0) begin
              state_q <= S_DIV;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              if (bus.alu_cnt == OP_DIVU) begin
                result_q <= '1;
                hi_q     <= bus.input1;
                zero_q   <= 1'b0;
                err_q    <= 1'b1;
              end else if (illegal_d) begin
                result_q <= '0;
                hi_q     <= '0;
                zero_q   <= 1'b1;
                err_q    <= 1'b1;
              end else begin
                result_q <= alu_res_d;
                hi_q     <= '0;
                zero_q   <= (alu_res_d == '0);
                err_q    <= 1'b0;
              end
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          b_q   <= mul_b_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_b_d;
            hi_q        <= mul_acc_d;
            zero_q      <= (mul_b_d == '0);
            err_q       <= 1'b0;
          end
        end
        S_DIV: begin
          acc_q <= div_acc_d;
          a_q   <= div_a_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= div_a_d;
            hi_q        <= div_acc_d;
            zero_q      <= (div_a_d == '0);
            err_q       <= 1'b0;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.hi        = hi_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule
